stream_demux: RTL and testbench
===============================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter WIDTH, 8, data width in bits.
REQ-002 SHALL have parameter N_OUT, 8, output channel count (power of two, 2..16).
REQ-003 SHALL have parameter SEL_W, $clog2(N_OUT), select width (derived).
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have rst  input  1  synchronous active-high reset.
REQ-006 SHALL have in_valid  input  1  input beat valid.
REQ-007 SHALL have in_ready  output  1  input beat accepted when in_valid & in_ready.
REQ-008 SHALL have in_data  input  WIDTH  input beat payload.
REQ-009 SHALL have in_sel  input  SEL_W  destination channel; sampled on packet first beat only.
REQ-010 SHALL have in_last  input  1  marks final beat of packet.
REQ-011 SHALL have ch_en  input  N_OUT  per-channel enable mask; sampled on packet first beat.
REQ-012 SHALL have out_valid  output  N_OUT  one-hot (or zero) per-channel valid.
REQ-013 SHALL have out_ready  input  N_OUT  per-channel ready.
REQ-014 SHALL have out_data  output  WIDTH  payload, shared by all channels.
REQ-015 SHALL have out_last  output  1  last flag, shared.
REQ-016 SHALL have drop_cnt  output  16  saturating count of dropped packets.

Function
REQ-017 SHALL implement FSM states IDLE, PKT, DROP; IDLE = awaiting first beat.
REQ-018 IDLE, accepted beat, ch_en[in_sel]=1: SHALL latch dest=in_sel and go to PKT, or stay IDLE if in_last.
REQ-019 IDLE, accepted beat, ch_en[in_sel]=0: SHALL discard beat, increment drop_cnt, and go to DROP unless in_last (then stay IDLE).
REQ-020 PKT: SHALL route every beat to the latched dest; in_sel and ch_en ignored; accepted in_last returns to IDLE.
REQ-021 DROP: SHALL hold in_ready=1 and discard beats; accepted in_last returns to IDLE.
REQ-022 Output SHALL be a one-entry register: forwarded beat appears on out_* exactly 1 cycle after acceptance.
REQ-023 out_valid SHALL be one-hot at bit dest while the register is full, else all zero.
REQ-024 Outside DROP, in_ready SHALL equal !full | out_ready[dest_reg] (full-throughput pass-through, no combinational in_valid->in_ready path).
REQ-025 Register SHALL load and drain in the same cycle when full and out_ready[dest_reg]=1.
REQ-026 out_data/out_last SHALL stay stable while out_valid is asserted and not taken.
REQ-027 drop_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-028 A channel stalled by out_ready=0 SHALL back-pressure the input; no beat lost or duplicated.
REQ-029 ch_en changes mid-packet SHALL NOT affect the packet in progress.

Reset
REQ-030 rst SHALL force state=IDLE, out_valid=0, out_data=0, out_last=0, drop_cnt=0, dest=0 on the next clk edge.
REQ-031 in_ready SHALL be 0 while rst is high.
REQ-032 Reset mid-packet SHALL abandon the packet; next accepted beat is treated as a first beat.

Structure
REQ-033 Package stream_demux_pkg SHALL hold the state enum and the drop-counter width constant (16).
REQ-034 Output register SHALL be a sub-module stream_demux_reg (one-entry valid/ready slice: data, last, dest).
REQ-035 Top SHALL contain only FSM, channel decode, drop counter, and stream_demux_reg instance.

Verification
REQ-036 N_OUT=8, ch_en=8'hFF, 3-beat packet sel=5, data 0x11,0x22,0x33 -> out_valid=8'h20 each following cycle, last on 0x33.
REQ-037 sel=2 packet, out_ready[2]=0 for 4 cycles -> in_ready=0 after first beat, data held, none lost on release.
REQ-038 ch_en=8'hFB, 2-beat packet sel=2 -> no out_valid, in_ready=1 throughout, drop_cnt 0->1.
REQ-039 sel changes 3->6 mid-packet -> all beats exit channel 3.
REQ-040 rst asserted on beat 2 of 4 -> out_valid=0, drop_cnt=0; next beat with sel=1 routes to channel 1.
REQ-041 Force 65536 dropped single-beat packets -> drop_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg
//   Shared definitions for the stream demultiplexer: FSM state encoding,
//   drop-counter width and a saturating-increment helper.
package stream_demux_pkg;

    localparam int DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // waiting for the first beat of a packet
        ST_PKT  = 2'd1,  // forwarding to the latched destination
        ST_DROP = 2'd2   // swallowing the rest of a rejected packet
    } state_t;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/stream_demux_reg.sv
// stream_demux_reg
//   One-entry valid/ready register slice carrying data, last and the
//   destination channel. Can load and drain in the same cycle, so a
//   continuously ready sink sees full throughput.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_valid/s_ready load strobe / slice can accept (empty or draining)
//   s_data/s_last/s_dest  beat to store
//   m_valid/m_ready slice full / sink taking the stored beat
//   m_data/m_last/m_dest  stored beat (held stable while not taken)
module stream_demux_reg
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    input  logic [SEL_W-1:0] s_dest,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [SEL_W-1:0] m_dest
);

    logic full;

    // Ready depends only on state and the sink, never on s_valid.
    assign s_ready = !full || m_ready;
    assign m_valid = full;

    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= 1'b0;
            m_data <= '0;
            m_last <= 1'b0;
            m_dest <= '0;
        end else if (s_valid && s_ready) begin
            full   <= 1'b1;
            m_data <= s_data;
            m_last <= s_last;
            m_dest <= s_dest;
        end else if (m_ready) begin
            full   <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// stream_demux
//   Packet demultiplexer: the first beat of each packet picks a destination
//   channel (in_sel). Enabled channels get the whole packet through a
//   one-entry output register; packets aimed at a disabled channel are
//   swallowed and counted in a saturating drop counter.
// Ports:
//   clk, rst                synchronous active-high reset
//   in_valid/in_ready       input handshake
//   in_data/in_last/in_sel  input beat, in_sel used on first beat only
//   ch_en                   channel enable mask, sampled on first beat
//   out_valid[N_OUT]        one-hot valid of the destination channel
//   out_ready[N_OUT]        per-channel ready
//   out_data/out_last       shared payload and last flag
//   drop_cnt                dropped-packet count, saturating
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_OUT = 8,
    parameter int SEL_W = $clog2(N_OUT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_last,
    input  logic [N_OUT-1:0]      ch_en,
    output logic [N_OUT-1:0]      out_valid,
    input  logic [N_OUT-1:0]      out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] dest;
    logic [SEL_W-1:0] fwd_dest;
    logic             fwd_load;
    logic             drop_inc;
    logic             accept;
    logic             sel_en;
    logic             reg_ready;
    logic             reg_valid;
    logic [SEL_W-1:0] reg_dest;

    // DROP never touches the output register, so it can always sink beats.
    assign in_ready = !rst && ((state == ST_DROP) || reg_ready);
    assign accept   = in_valid && in_ready;
    assign sel_en   = ch_en[in_sel];

    // State register, latched destination and drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            dest     <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (fwd_load) dest <= fwd_dest;
            if (drop_inc) drop_cnt <= sat_inc(drop_cnt);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                // A single-beat packet never leaves IDLE.
                if (accept && !in_last) state_nxt = sel_en ? ST_PKT : ST_DROP;
            end
            ST_PKT, ST_DROP: begin
                if (accept && in_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: forward strobe, its destination, drop strobe
    always_comb begin
        fwd_load = 1'b0;
        fwd_dest = dest;
        drop_inc = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (sel_en) begin
                        fwd_load = 1'b1;
                        fwd_dest = in_sel;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            ST_PKT:  fwd_load = accept;
            default: ;
        endcase
    end

    stream_demux_reg #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_reg (
        .clk     (clk),
        .rst     (rst),
        .s_valid (fwd_load),
        .s_ready (reg_ready),
        .s_data  (in_data),
        .s_last  (in_last),
        .s_dest  (fwd_dest),
        .m_valid (reg_valid),
        .m_ready (out_ready[reg_dest]),
        .m_data  (out_data),
        .m_last  (out_last),
        .m_dest  (reg_dest)
    );

    // Channel decode
    always_comb begin
        out_valid = '0;
        if (reg_valid) out_valid[reg_dest] = 1'b1;
    end

endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic        in_last;
    logic [7:0]  ch_en;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [15:0] drop_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stream_demux #(.WIDTH(8), .N_OUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .ch_en     (ch_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .drop_cnt  (drop_cnt)
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic [2:0]  sel;
        logic [7:0]  d;
        logic        l;
        logic [7:0]  en;
        logic [7:0]  ordy;
        logic        e_ir;
        logic [7:0]  e_ov;
        logic        chk_d;
        logic [7:0]  e_od;
        logic        e_ol;
        logic [15:0] e_dc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic v, logic [2:0] sel, logic [7:0] d, logic l,
                                logic [7:0] en, logic [7:0] ordy, logic e_ir, logic [7:0] e_ov,
                                logic chk_d, logic [7:0] e_od, logic e_ol, logic [15:0] e_dc);
        vec_t x;
        x.rst = r; x.v = v; x.sel = sel; x.d = d; x.l = l; x.en = en; x.ordy = ordy;
        x.e_ir = e_ir; x.e_ov = e_ov; x.chk_d = chk_d; x.e_od = e_od; x.e_ol = e_ol; x.e_dc = e_dc;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [2:0] sel, input logic [7:0] d,
                         input logic l, input logic [7:0] en, input logic [7:0] ordy);
        rst = r; in_valid = v; in_sel = sel; in_data = d; in_last = l; ch_en = en; out_ready = ordy;
    endtask

    initial begin
        drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 8'hFF, 8'hFF);
        repeat (2) @(posedge clk);

        //           rst v  sel  data   l  ch_en  ordy   ir  ov     cd od     ol dc
        // reset state
        vq.push_back(mk(1, 0, 0, 8'h00, 0, 8'hFF, 8'hFF, 0, 8'h00, 1, 8'h00, 0, 0));
        // 3-beat packet to channel 5
        vq.push_back(mk(0, 1, 5, 8'h11, 0, 8'hFF, 8'hFF, 1, 8'h00, 1, 8'h00, 0, 0));
        vq.push_back(mk(0, 1, 5, 8'h22, 0, 8'hFF, 8'hFF, 1, 8'h20, 1, 8'h11, 0, 0));
        vq.push_back(mk(0, 1, 0, 8'h33, 1, 8'hFF, 8'hFF, 1, 8'h20, 1, 8'h22, 0, 0));
        vq.push_back(mk(0, 0, 0, 8'h00, 0, 8'hFF, 8'hFF, 1, 8'h20, 1, 8'h33, 1, 0));
        vq.push_back(mk(0, 0, 0, 8'h00, 0, 8'hFF, 8'hFF, 1, 8'h00, 0, 8'h00, 0, 0));
        // 2-beat packet to disabled channel 2 is dropped
        vq.push_back(mk(0, 1, 2, 8'hAA, 0, 8'hFB, 8'hFF, 1, 8'h00, 0, 8'h00, 0, 0));
        vq.push_back(mk(0, 1, 2, 8'hBB, 1, 8'hFB, 8'hFF, 1, 8'h00, 0, 8'h00, 0, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 0, 8'hFF, 8'hFF, 1, 8'h00, 0, 8'h00, 0, 1));
        // sel 3 -> 6 and ch_en cleared mid-packet: stays on channel 3
        vq.push_back(mk(0, 1, 3, 8'h01, 0, 8'hFF, 8'hFF, 1, 8'h00, 0, 8'h00, 0, 1));
        vq.push_back(mk(0, 1, 6, 8'h02, 0, 8'h00, 8'hFF, 1, 8'h08, 1, 8'h01, 0, 1));
        vq.push_back(mk(0, 1, 6, 8'h03, 1, 8'h00, 8'hFF, 1, 8'h08, 1, 8'h02, 0, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 0, 8'hFF, 8'hFF, 1, 8'h08, 1, 8'h03, 1, 1));
        vq.push_back(mk(0, 0, 0, 8'h00, 0, 8'hFF, 8'hFF, 1, 8'h00, 0, 8'h00, 0, 1));
        // single-beat drop, then single-beat packet to channel 7
        vq.push_back(mk(0, 1, 1, 8'h55, 1, 8'hFD, 8'hFF, 1, 8'h00, 0, 8'h00, 0, 1));
        vq.push_back(mk(0, 1, 7, 8'hC0, 1, 8'hFF, 8'hFF, 1, 8'h00, 0, 8'h00, 0, 2));
        vq.push_back(mk(0, 0, 0, 8'h00, 0, 8'hFF, 8'hFF, 1, 8'h80, 1, 8'hC0, 1, 2));
        vq.push_back(mk(0, 0, 0, 8'h00, 0, 8'hFF, 8'hFF, 1, 8'h00, 0, 8'h00, 0, 2));
        // channel 2 stalled for 4 cycles: back-pressure, data held, nothing lost
        vq.push_back(mk(0, 1, 2, 8'hA1, 0, 8'hFF, 8'hFB, 1, 8'h00, 0, 8'h00, 0, 2));
        vq.push_back(mk(0, 1, 5, 8'hA2, 0, 8'hFF, 8'hFB, 0, 8'h04, 1, 8'hA1, 0, 2));
        vq.push_back(mk(0, 1, 5, 8'hA2, 0, 8'hFF, 8'hFB, 0, 8'h04, 1, 8'hA1, 0, 2));
        vq.push_back(mk(0, 1, 5, 8'hA2, 0, 8'hFF, 8'hFB, 0, 8'h04, 1, 8'hA1, 0, 2));
        vq.push_back(mk(0, 1, 5, 8'hA2, 0, 8'hFF, 8'hFF, 1, 8'h04, 1, 8'hA1, 0, 2));
        vq.push_back(mk(0, 1, 5, 8'hA3, 1, 8'hFF, 8'hFF, 1, 8'h04, 1, 8'hA2, 0, 2));
        vq.push_back(mk(0, 0, 0, 8'h00, 0, 8'hFF, 8'hFF, 1, 8'h04, 1, 8'hA3, 1, 2));
        vq.push_back(mk(0, 0, 0, 8'h00, 0, 8'hFF, 8'hFF, 1, 8'h00, 0, 8'h00, 0, 2));

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].v, vq[i].sel, vq[i].d, vq[i].l, vq[i].en, vq[i].ordy);
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vq[i].e_ir));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vq[i].e_ov));
            chk($sformatf("v%0d drop_cnt", i), 32'(drop_cnt), 32'(vq[i].e_dc));
            if (vq[i].chk_d) begin
                chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vq[i].e_od));
                chk($sformatf("v%0d out_last", i), 32'(out_last), 32'(vq[i].e_ol));
            end
        end

        // Reset on beat 2 of a 4-beat packet to channel 4
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd4, 8'h10, 1'b0, 8'hFF, 8'hFF);
        @(negedge clk);
        drive(1'b1, 1'b1, 3'd4, 8'h20, 1'b0, 8'hFF, 8'hFF);
        #1;
        chk("rst in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd1, 8'h77, 1'b1, 8'hFF, 8'hFF);
        #1;
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst out_data", 32'(out_data), 32'h0);
        chk("rst out_last", 32'(out_last), 32'h0);
        chk("rst drop_cnt", 32'(drop_cnt), 32'h0);
        chk("post-rst in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'hFF, 8'hFF);
        #1;
        chk("post-rst out_valid", 32'(out_valid), 32'h02);
        chk("post-rst out_data", 32'(out_data), 32'h77);
        chk("post-rst out_last", 32'(out_last), 32'h1);

        // Back-to-back single-beat drops until the counter saturates
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 8'hFF);
        repeat (65534) @(posedge clk);
        @(negedge clk); #1;
        chk("sat drop_cnt 65534", 32'(drop_cnt), 32'hFFFE);
        chk("sat in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        @(negedge clk); #1;
        chk("sat drop_cnt 65535", 32'(drop_cnt), 32'hFFFF);
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        chk("sat drop_cnt held", 32'(drop_cnt), 32'hFFFF);
        chk("sat out_valid", 32'(out_valid), 32'h0);
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'hFF, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
